// File: rtl/sb_msg_tx_engine.sv
// Sideband message transmit engine: round-robin arbitration over NUM_CH requesters,
// even-parity packet build, FIFO handoff and an optional stoppable response timeout.
module sb_msg_tx_engine #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 16,
  parameter int PKT_W       = 64,
  parameter int TIMEOUT_CYC = 8000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req_valid,
  input  logic [NUM_CH-1:0]        i_expect_rsp,
  input  logic [4*NUM_CH-1:0]      i_msg_no,
  input  logic [3*NUM_CH-1:0]      i_msg_info,
  input  logic [DATA_W*NUM_CH-1:0] i_data,
  output logic [NUM_CH-1:0]        o_req_ack,
  input  logic                     i_fifo_full,
  input  logic                     i_ser_done,
  input  logic                     i_rsp_delivered,
  input  logic                     i_stop_cnt,
  output logic [PKT_W-1:0]         o_tx_data,
  output logic                     o_write_enable,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_time_out,
  output logic [CH_W-1:0]          o_done_ch
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_SER,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                exp_rsp_q, exp_rsp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                time_out_q, time_out_d;
  logic [CH_W-1:0]     done_ch_q, done_ch_d;

  logic [3:0]          msg_no_a   [NUM_CH];
  logic [2:0]          msg_info_a [NUM_CH];
  logic [DATA_W-1:0]   data_a     [NUM_CH];
  logic                grant_vld;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W-1:0]     cand;

  // Parity lands in the MSB so the full packet always has an even popcount.
  function automatic logic [PKT_W-1:0] build_pkt(input logic [3:0]        no,
                                                 input logic [2:0]        info,
                                                 input logic [DATA_W-1:0] data,
                                                 input logic [CH_W-1:0]   ch);
    logic [PKT_W-1:0] p;
    p                   = '0;
    p[3:0]              = no;
    p[6:4]              = info;
    p[7 +: DATA_W]      = data;
    p[7 + DATA_W +: CH_W] = ch;
    p[PKT_W-1]          = ^p;
    return p;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      msg_no_a[k]   = i_msg_no[4*k +: 4];
      msg_info_a[k] = i_msg_info[3*k +: 3];
      data_a[k]     = i_data[DATA_W*k +: DATA_W];
    end
  end

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!grant_vld && i_req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    exp_rsp_d  = exp_rsp_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    ack_d      = '0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    time_out_d = 1'b0;
    done_ch_d  = done_ch_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d         = S_WRITE;
          ptr_d           = grant_ch;
          ch_d            = grant_ch;
          exp_rsp_d       = i_expect_rsp[grant_ch];
          pkt_d           = build_pkt(msg_no_a[grant_ch], msg_info_a[grant_ch],
                                      data_a[grant_ch], grant_ch);
          ack_d[grant_ch] = 1'b1;
          busy_d          = 1'b1;
        end
      end
      S_WRITE: begin
        if (!i_fifo_full) state_d = S_WAIT_SER;
      end
      S_WAIT_SER: begin
        if (i_ser_done) begin
          if (exp_rsp_q) begin
            state_d = S_WAIT_RSP;
            cnt_d   = '0;
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_ch_d = ch_q;
          end
        end
      end
      S_WAIT_RSP: begin
        if (i_rsp_delivered) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_ch_d = ch_q;
        end else if (i_stop_cnt) begin
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          time_out_d = 1'b1;
          done_ch_d  = ch_q;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= CH_W'(NUM_CH - 1);
      ch_q       <= '0;
      exp_rsp_q  <= 1'b0;
      cnt_q      <= '0;
      pkt_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      time_out_q <= 1'b0;
      done_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      exp_rsp_q  <= exp_rsp_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      time_out_q <= time_out_d;
      done_ch_q  <= done_ch_d;
    end
  end

  assign o_write_enable = (state_q == S_WRITE) && !i_fifo_full;
  assign o_tx_data      = pkt_q;
  assign o_req_ack      = ack_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_time_out     = time_out_q;
  assign o_done_ch      = done_ch_q;

endmodule

// File: tb/tb_sb_msg_tx_engine.sv
// Randomised and directed bench for sb_msg_tx_engine against a transaction-level model.
module tb_sb_msg_tx_engine;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int PKT_W  = 64;
  localparam int TOC    = 16;
  localparam int CH_W   = 1;

  logic                     clk = 1'b0;
  logic                     i_rst;
  logic [NUM_CH-1:0]        i_req_valid;
  logic [NUM_CH-1:0]        i_expect_rsp;
  logic [4*NUM_CH-1:0]      i_msg_no;
  logic [3*NUM_CH-1:0]      i_msg_info;
  logic [DATA_W*NUM_CH-1:0] i_data;
  logic [NUM_CH-1:0]        o_req_ack;
  logic                     i_fifo_full;
  logic                     i_ser_done;
  logic                     i_rsp_delivered;
  logic                     i_stop_cnt;
  logic [PKT_W-1:0]         o_tx_data;
  logic                     o_write_enable;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_time_out;
  logic [CH_W-1:0]          o_done_ch;

  sb_msg_tx_engine #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PKT_W(PKT_W), .TIMEOUT_CYC(TOC)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_expect_rsp(i_expect_rsp),
    .i_msg_no(i_msg_no), .i_msg_info(i_msg_info), .i_data(i_data), .o_req_ack(o_req_ack),
    .i_fifo_full(i_fifo_full), .i_ser_done(i_ser_done), .i_rsp_delivered(i_rsp_delivered),
    .i_stop_cnt(i_stop_cnt), .o_tx_data(o_tx_data), .o_write_enable(o_write_enable),
    .o_busy(o_busy), .o_done(o_done), .o_time_out(o_time_out), .o_done_ch(o_done_ch)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int last_g;
  int msg_a  [NUM_CH];
  int info_a [NUM_CH];
  int data_a [NUM_CH];
  bit exp_a  [NUM_CH];
  bit         const_en = 1'b0;
  logic [63:0] const_pkt;
  int wc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields();
    for (int c = 0; c < NUM_CH; c++) begin
      i_msg_no[4*c +: 4]          = 4'(msg_a[c]);
      i_msg_info[3*c +: 3]        = 3'(info_a[c]);
      i_data[DATA_W*c +: DATA_W]  = DATA_W'(data_a[c]);
      i_expect_rsp[c]             = exp_a[c];
    end
  endtask

  task automatic rand_fields(input int c);
    msg_a[c]  = int'($urandom_range(0, 15));
    info_a[c] = int'($urandom_range(0, 7));
    data_a[c] = int'($urandom_range(0, 65535));
  endtask

  // Packet from the field layout rules, with parity making the popcount even.
  function automatic logic [63:0] model_pkt(input int c);
    logic [63:0] p;
    p = 64'(msg_a[c]) + (64'(info_a[c]) * 64'd16) + (64'(data_a[c]) * 64'd128)
        + (64'(c) << (7 + DATA_W));
    if ($countones(p) % 2 == 1) p = p + (64'd1 << 63);
    return p;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx"},   o_tx_data, 0);
    chk({tag, "_ack"},  o_req_ack, 0);
    chk({tag, "_we"},   o_write_enable, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_to"},   o_time_out, 0);
    chk({tag, "_dch"},  o_done_ch, 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    #1 chk_all_zero("rst");
    tick();
    i_rst  = 1'b0;
    last_g = NUM_CH - 1;
  endtask

  task automatic do_txn(input logic [1:0] vmask, input bit hold, input int full_cyc,
                        input int ser_dly, input bit rsp_in_ser, input int rsp_at,
                        input int stall_at, input int stall_len, input int abort_at,
                        output int wait_cyc);
    int g;
    logic [63:0] exp_pkt;
    bit exp_r;
    int used;
    bit fin;
    bit rsp_win;
    int j;
    g = -1;
    for (int i = 1; i <= NUM_CH; i++)
      if (g < 0 && vmask[(last_g + i) % NUM_CH]) g = (last_g + i) % NUM_CH;
    exp_pkt = model_pkt(g);
    exp_r   = exp_a[g];
    wait_cyc = 0;
    i_req_valid = vmask;
    i_fifo_full = (full_cyc > 0);
    #1 chk("idle_busy", o_busy, 0);
    tick();
    if (!hold) i_req_valid = '0;
    last_g = g;
    #1;
    chk("ack", o_req_ack, 64'd1 << g);
    chk("pkt", o_tx_data, exp_pkt);
    chk("busy_w", o_busy, 1);
    if (const_en) chk("pkt_const", o_tx_data, const_pkt);
    rand_fields(g);
    drive_fields();
    for (int k = 0; k <= full_cyc; k++) begin
      i_fifo_full = (k < full_cyc);
      #1;
      chk("we", o_write_enable, (k == full_cyc) ? 1 : 0);
      chk("pkt_hold", o_tx_data, exp_pkt);
      if (k > 0) chk("ack_once", o_req_ack, 0);
      tick();
    end
    for (int k = 0; k <= ser_dly; k++) begin
      i_ser_done      = (k == ser_dly);
      i_rsp_delivered = rsp_in_ser;
      #1;
      chk("we_ser", o_write_enable, 0);
      chk("done_ser", o_done, 0);
      chk("pkt_ser", o_tx_data, exp_pkt);
      tick();
    end
    i_ser_done      = 1'b0;
    i_rsp_delivered = 1'b0;
    if (exp_r) begin
      used = 0; fin = 1'b0; rsp_win = 1'b0; j = 0;
      while (!fin) begin
        if (j == abort_at) begin
          i_rst = 1'b1;
          #1 chk_all_zero("abort");
          tick();
          i_rst = 1'b0;
          last_g = NUM_CH - 1;
          i_stop_cnt = 1'b0;
          return;
        end
        i_rsp_delivered = (j == rsp_at);
        i_stop_cnt      = (j >= stall_at && j < stall_at + stall_len);
        #1;
        chk("wr_done", o_done, 0);
        chk("wr_to", o_time_out, 0);
        chk("wr_busy", o_busy, 1);
        if (i_rsp_delivered) begin
          fin = 1'b1; rsp_win = 1'b1;
        end else if (!i_stop_cnt) begin
          used++;
          if (used == TOC) fin = 1'b1;
        end
        j++;
        tick();
      end
      i_rsp_delivered = 1'b0;
      i_stop_cnt      = 1'b0;
      wait_cyc = j;
      if (!rsp_win) begin
        #1;
        chk("to_pulse", o_time_out, 1);
        chk("to_done", o_done, 0);
        chk("to_busy", o_busy, 0);
        chk("to_ch", o_done_ch, g);
        tick();
        #1 chk("to_end", o_time_out, 0);
        return;
      end
    end
    #1;
    chk("done", o_done, 1);
    chk("done_to", o_time_out, 0);
    chk("done_ch", o_done_ch, g);
    chk("done_busy", o_busy, 1);
    tick();
    #1;
    chk("done_end", o_done, 0);
    chk("idle_ret", o_busy, 0);
    chk("dch_hold", o_done_ch, g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_req_valid = '0; i_fifo_full = 0; i_ser_done = 0;
    i_rsp_delivered = 0; i_stop_cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin rand_fields(c); exp_a[c] = 1'b0; end
    drive_fields();
    do_reset();

    // Directed single packet with known encoding
    msg_a[0] = 5; info_a[0] = 2; data_a[0] = 'hABCD; exp_a[0] = 0; drive_fields();
    const_en = 1'b1; const_pkt = 64'h8000_0000_0055_E6A5;
    do_txn(2'b01, 0, 0, 0, 0, -1, -1, 0, -1, wc);
    const_en = 1'b0;

    // Round robin with both requesters held high
    do_reset();
    exp_a[0] = 0; exp_a[1] = 0; drive_fields();
    for (int n = 0; n < 4; n++) do_txn(2'b11, 1, 0, 0, 0, -1, -1, 0, -1, wc);
    i_req_valid = '0;
    tick();

    // FIFO backpressure for 5 cycles
    do_txn(2'b10, 0, 5, 1, 0, -1, -1, 0, -1, wc);

    // Timeout with a 3-cycle counter stall
    exp_a[0] = 1; drive_fields();
    do_txn(2'b01, 0, 0, 0, 0, -1, 6, 3, -1, wc);

    // Response on the terminal-count cycle wins
    exp_a[1] = 1; drive_fields();
    do_txn(2'b10, 0, 0, 0, 0, TOC - 1, -1, 0, -1, wc);

    // Response during serialisation is ignored
    exp_a[0] = 1; drive_fields();
    do_txn(2'b01, 0, 1, 2, 1, -1, -1, 0, -1, wc);

    // Reset in WAIT_RSP after ch0 was granted; pointer must restart
    exp_a[1] = 0; drive_fields();
    do_txn(2'b10, 0, 0, 0, 0, -1, -1, 0, -1, wc);
    exp_a[0] = 1; drive_fields();
    do_txn(2'b01, 0, 0, 0, 0, -1, -1, 0, 4, wc);
    exp_a[0] = 0; exp_a[1] = 0; drive_fields();
    do_txn(2'b11, 0, 0, 0, 0, -1, -1, 0, -1, wc);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      int rsp_at;
      for (int c = 0; c < NUM_CH; c++) exp_a[c] = 1'($urandom_range(0, 1));
      drive_fields();
      rsp_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
      do_txn(2'($urandom_range(1, 3)), 0, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rsp_at,
             int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), -1, wc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
